spwm_mc: RTL and testbench

- Multi-channel sweeping PWM generator; next generation of the single-channel sweep PWM.
- NCH channels share one period counter, so all channel edges are period-aligned.
- Each channel has its own sweep engine with selectable mode (hold / sawtooth / triangle), output polarity and shadowed configuration, applied glitch-free at the period boundary.
- Drives LED-dimming and motor-phase outputs from a CPU-style config write port.

---
 rtl/spwm_mc.sv | 228 ++++++++++++++++++++++
 tb/tb_spwm_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spwm_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spwm_mc                                                      |
// | Description : Multi-channel sweeping PWM generator. One shared period      |
// |               counter keeps every channel edge period-aligned. Each        |
// |               channel has a shadowed configuration (duty init, duty delta, |
// |               repeat count, polarity, sweep mode) applied glitch-free at   |
// |               the period boundary, and a sweep engine (hold / sawtooth /   |
// |               triangle) that steps the duty every k_max+1 periods.         |
// | Ports       : clk, rstn       clock, asynchronous active-low reset         |
// |               en              run enable, low = restart state              |
// |               period          period length minus one                      |
// |               cfg_we/ch/sel   config write strobe, channel, field select   |
// |               cfg_wdata       config write data                            |
// |               clr_it          clears the sticky boundary flag              |
// |               io              PWM outputs (registered)                     |
// |               evt             one-cycle sweep event pulses                 |
// |               it              sticky period-boundary flag                  |
// | Revision    : 1.0  initial multi-channel release                           |
// +----------------------------------------------------------------------------+
module spwm_mc #(
    parameter int NCH    = 4,
    parameter int CWIDTH = 32,
    parameter int KWIDTH = 10,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [CWIDTH-1:0] period,
    input  logic              cfg_we,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [CWIDTH-1:0] cfg_wdata,
    input  logic              clr_it,
    output logic [NCH-1:0]    io,
    output logic [NCH-1:0]    evt,
    output logic              it
);

    localparam logic [1:0] SEL_INIT  = 2'd0;
    localparam logic [1:0] SEL_DELTA = 2'd1;
    localparam logic [1:0] SEL_KMAX  = 2'd2;
    localparam logic [1:0] SEL_CTRL  = 2'd3;

    localparam logic [1:0] MODE_SAW  = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;

    logic [CWIDTH-1:0] cnt;
    logic [CWIDTH-1:0] period_act;
    logic              bnd;

    // period_act starts at 0, so the first enabled cycle is a boundary that
    // loads the real period.
    assign bnd = en && (cnt == period_act);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            period_act <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (bnd) begin
            cnt        <= '0;
            period_act <= period;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            it <= 1'b0;
        end else if (bnd) begin
            it <= 1'b1;
        end else if (clr_it) begin
            it <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CWIDTH-1:0] sh_init;
        logic [CWIDTH-1:0] sh_delta;
        logic [KWIDTH-1:0] sh_kmax;
        logic [2:0]        sh_ctrl;
        logic [CWIDTH-1:0] act_init;
        logic [CWIDTH-1:0] act_delta;
        logic [KWIDTH-1:0] act_kmax;
        logic [2:0]        act_ctrl;
        logic [CWIDTH-1:0] d;
        logic [KWIDTH-1:0] k;
        logic              dir_down;
        logic              pending;
        logic              io_q;
        logic              evt_q;
        logic              wr;
        logic              pol;
        logic [CWIDTH:0]   sum;
        logic              over;
        logic [CWIDTH-1:0] d_nxt;
        logic              dir_nxt;
        logic              step_evt;

        assign wr   = cfg_we && (cfg_ch == CHW'(i));
        assign pol  = act_ctrl[2];
        // One extra bit so d+delta can never wrap before the compare.
        assign sum  = {1'b0, d} + {1'b0, act_delta};
        assign over = sum > {1'b0, period_act};

        // Sweep step taken when the repeat counter expires. A zero delta
        // freezes the duty and suppresses events in every mode.
        always_comb begin
            d_nxt    = d;
            dir_nxt  = dir_down;
            step_evt = 1'b0;
            if (act_delta != '0) begin
                case (act_ctrl[1:0])
                    MODE_SAW: begin
                        if (over) begin
                            d_nxt    = act_init;
                            step_evt = 1'b1;
                        end else begin
                            d_nxt = sum[CWIDTH-1:0];
                        end
                    end
                    MODE_TRI: begin
                        if (!dir_down) begin
                            if (over) begin
                                dir_nxt  = 1'b1;
                                d_nxt    = (d >= act_delta) ? (d - act_delta) : '0;
                                step_evt = 1'b1;
                            end else begin
                                d_nxt = sum[CWIDTH-1:0];
                            end
                        end else begin
                            if (d < act_delta) begin
                                dir_nxt  = 1'b0;
                                d_nxt    = sum[CWIDTH-1:0];
                                step_evt = 1'b1;
                            end else begin
                                d_nxt = d - act_delta;
                            end
                        end
                    end
                    default: begin
                        d_nxt = d;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sh_init   <= '0;
                sh_delta  <= '0;
                sh_kmax   <= '0;
                sh_ctrl   <= '0;
                act_init  <= '0;
                act_delta <= '0;
                act_kmax  <= '0;
                act_ctrl  <= '0;
                d         <= '0;
                k         <= '0;
                dir_down  <= 1'b0;
                pending   <= 1'b0;
                io_q      <= 1'b0;
                evt_q     <= 1'b0;
            end else begin
                if (wr) begin
                    case (cfg_sel)
                        SEL_INIT:  sh_init  <= cfg_wdata;
                        SEL_DELTA: sh_delta <= cfg_wdata;
                        SEL_KMAX:  sh_kmax  <= cfg_wdata[KWIDTH-1:0];
                        SEL_CTRL:  sh_ctrl  <= cfg_wdata[2:0];
                        default:   sh_ctrl  <= sh_ctrl;
                    endcase
                end

                // A write in the same cycle as an apply keeps pending set so
                // the new shadow value is picked up at the following boundary.
                if (wr) begin
                    pending <= 1'b1;
                end else if (!en || bnd) begin
                    pending <= 1'b0;
                end

                if (!en) begin
                    act_init  <= sh_init;
                    act_delta <= sh_delta;
                    act_kmax  <= sh_kmax;
                    act_ctrl  <= sh_ctrl;
                    d         <= sh_init;
                    k         <= '0;
                    dir_down  <= 1'b0;
                    io_q      <= pol;
                    evt_q     <= 1'b0;
                end else begin
                    io_q  <= (cnt < d) ? ~pol : pol;
                    evt_q <= 1'b0;
                    if (bnd) begin
                        if (pending) begin
                            act_init  <= sh_init;
                            act_delta <= sh_delta;
                            act_kmax  <= sh_kmax;
                            act_ctrl  <= sh_ctrl;
                            d         <= sh_init;
                            k         <= '0;
                            dir_down  <= 1'b0;
                        end else if (k != act_kmax) begin
                            k <= k + 1'b1;
                        end else begin
                            k        <= '0;
                            d        <= d_nxt;
                            dir_down <= dir_nxt;
                            evt_q    <= step_evt;
                        end
                    end
                end
            end
        end

        assign io[i]  = io_q;
        assign evt[i] = evt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_spwm_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spwm_mc                                                   |
// | Description : Self-checking bench for spwm_mc (NCH=2, CWIDTH=8, KWIDTH=4,  |
// |               period=9). Table of sweep configurations with hand-computed |
// |               per-period duty and event sequences, plus directed          |
// |               sequences for shadowing, it, enable and reset behaviour.    |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spwm_mc;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int KW  = 4;
    localparam int NV  = 11;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] period = 8'd9;
    logic          cfg_we = 1'b0;
    logic [0:0]    cfg_ch = 1'b0;
    logic [1:0]    cfg_sel = 2'd0;
    logic [CW-1:0] cfg_wdata = '0;
    logic          clr_it = 1'b0;
    logic [NCH-1:0] io;
    logic [NCH-1:0] evt;
    logic          it;

    int total = 0;
    int bad   = 0;

    // duty: one nibble per period window, window 0 in the most significant
    // nibble, holding the number of cycles io[0] is high in that window.
    // ev: one bit per window, window 0 in the MSB.
    typedef struct packed {
        logic [CW-1:0]   init;
        logic [CW-1:0]   delta;
        logic [KW-1:0]   kmax;
        logic [2:0]      ctrl;
        logic [9:0][3:0] duty;
        logic [9:0]      ev;
    } vec_t;

    vec_t vecs [NV];

    spwm_mc #(.NCH(NCH), .CWIDTH(CW), .KWIDTH(KW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .period    (period),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .clr_it    (clr_it),
        .io        (io),
        .evt       (evt),
        .it        (it)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [7:0] init, input logic [7:0] delta,
                                 input logic [3:0] kmax, input logic [2:0] ctrl,
                                 input logic [39:0] duty, input logic [9:0] ev);
        vec_t v;
        v.init  = init;
        v.delta = delta;
        v.kmax  = kmax;
        v.ctrl  = ctrl;
        v.duty  = duty;
        v.ev    = ev;
        return v;
    endfunction

    // Expected io[0] pattern for one window (bit s = sample s after cnt=0):
    // pol 0 drives high first, pol 1 drives high last.
    function automatic logic [9:0] exp_pat(input int h, input logic pol);
        int m;
        m = (1 << h) - 1;
        if (pol) m = m << (10 - h);
        return m[9:0];
    endfunction

    task automatic wr(input logic ch, input logic [1:0] sel, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_sel   = sel;
        cfg_wdata = data;
        tick;
        cfg_we    = 1'b0;
    endtask

    // Reset, enable, write channel 0 while the first period runs; the
    // config is applied at the boundary ending that period, right before
    // the first measured window.
    task automatic setup(input logic [7:0] init, input logic [7:0] delta,
                         input logic [3:0] kmax, input logic [2:0] ctrl);
        rstn   = 1'b0;
        en     = 1'b0;
        cfg_we = 1'b0;
        clr_it = 1'b0;
        tick;
        tick;
        rstn = 1'b1;
        tick;
        en = 1'b1;
        tick;
        wr(1'b0, 2'd0, init);
        wr(1'b0, 2'd1, delta);
        wr(1'b0, 2'd2, {4'b0, kmax});
        wr(1'b0, 2'd3, {5'b0, ctrl});
        repeat (6) tick;
    endtask

    // One period window of 10 cycles; optional duty_init write to ch0
    // before sample wr_s.
    task automatic window(input int wr_s, input logic [7:0] wr_init,
                          output logic [9:0] pat, output int ev0,
                          output int hi1, output int ev1);
        pat = '0;
        ev0 = 0;
        hi1 = 0;
        ev1 = 0;
        for (int s = 0; s < 10; s++) begin
            if (s == wr_s) begin
                cfg_we    = 1'b1;
                cfg_ch    = 1'b0;
                cfg_sel   = 2'd0;
                cfg_wdata = wr_init;
            end
            tick;
            cfg_we = 1'b0;
            pat[s] = io[0];
            ev0 += int'(evt[0]);
            hi1 += int'(io[1]);
            ev1 += int'(evt[1]);
        end
    endtask

    initial begin
        logic [9:0] pat;
        int ev0, hi1, ev1, sum_hi1, sum_ev1;

        vecs[0]  = mkv(8'd3, 8'd0, 4'd0, 3'b000, 40'h3333333333, 10'b0000000000);
        vecs[1]  = mkv(8'd0, 8'd4, 4'd0, 3'b001, 40'h0480480480, 10'b0010010010);
        vecs[2]  = mkv(8'd0, 8'd4, 4'd1, 3'b010, 40'h0044884400, 10'b0000010001);
        vecs[3]  = mkv(8'd0, 8'd0, 4'd0, 3'b000, 40'h0000000000, 10'b0000000000);
        vecs[4]  = mkv(8'd10, 8'd0, 4'd0, 3'b000, 40'hAAAAAAAAAA, 10'b0000000000);
        vecs[5]  = mkv(8'd3, 8'd0, 4'd0, 3'b100, 40'h7777777777, 10'b0000000000);
        vecs[6]  = mkv(8'd5, 8'd0, 4'd0, 3'b001, 40'h5555555555, 10'b0000000000);
        vecs[7]  = mkv(8'd5, 8'd0, 4'd0, 3'b010, 40'h5555555555, 10'b0000000000);
        vecs[8]  = mkv(8'd2, 8'd3, 4'd2, 3'b001, 40'h2225558882, 10'b0000000010);
        vecs[9]  = mkv(8'd1, 8'd4, 4'd0, 3'b010, 40'h1595159515, 10'b0010101010);
        vecs[10] = mkv(8'd1, 8'd9, 4'd0, 3'b010, 40'h1090909090, 10'b1111111111);

        // Reset state
        tick;
        tick;
        check("rst_io", 32'(io), 32'd0);
        check("rst_evt", 32'(evt), 32'd0);
        check("rst_it", 32'(it), 32'd0);

        // Table-driven sweep sequences
        for (int v = 0; v < NV; v++) begin
            setup(vecs[v].init, vecs[v].delta, vecs[v].kmax, vecs[v].ctrl);
            sum_hi1 = 0;
            sum_ev1 = 0;
            for (int w = 0; w < 10; w++) begin
                window(-1, 8'd0, pat, ev0, hi1, ev1);
                check($sformatf("v%0d_w%0d_io", v, w), 32'(pat),
                      32'(exp_pat(int'(vecs[v].duty[9-w]), vecs[v].ctrl[2])));
                check($sformatf("v%0d_w%0d_evt", v, w), 32'(ev0), 32'(vecs[v].ev[9-w]));
                sum_hi1 += hi1;
                sum_ev1 += ev1;
            end
            check($sformatf("v%0d_ch1_io", v), 32'(sum_hi1), 32'd0);
            check($sformatf("v%0d_ch1_evt", v), 32'(sum_ev1), 32'd0);
        end

        // Shadowing: mid-period write applies next period; a write on the
        // boundary cycle applies one period later.
        setup(8'd3, 8'd0, 4'd0, 3'b000);
        window(4, 8'd7, pat, ev0, hi1, ev1);
        check("shadow_w0", 32'(pat), 32'(exp_pat(3, 1'b0)));
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("shadow_w1", 32'(pat), 32'(exp_pat(7, 1'b0)));
        window(9, 8'd2, pat, ev0, hi1, ev1);
        check("shadow_w2", 32'(pat), 32'(exp_pat(7, 1'b0)));
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("shadow_bnd_w3", 32'(pat), 32'(exp_pat(7, 1'b0)));
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("shadow_bnd_w4", 32'(pat), 32'(exp_pat(2, 1'b0)));

        // Sticky it: set at boundary, cleared by clr_it, set wins on collision
        setup(8'd3, 8'd0, 4'd0, 3'b000);
        check("it_set", 32'(it), 32'd1);
        clr_it = 1'b1;
        tick;
        clr_it = 1'b0;
        check("it_clr", 32'(it), 32'd0);
        repeat (8) tick;
        check("it_hold", 32'(it), 32'd0);
        clr_it = 1'b1;
        tick;
        check("it_set_wins", 32'(it), 32'd1);
        tick;
        clr_it = 1'b0;
        check("it_clr2", 32'(it), 32'd0);

        // en low mid-sweep: io=pol, no events, it not set, restart from init
        setup(8'd0, 8'd4, 4'd0, 3'b101);
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("en_w0", 32'(pat), 32'(exp_pat(10, 1'b1)));
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("en_w1", 32'(pat), 32'(exp_pat(6, 1'b1)));
        repeat (3) tick;
        en     = 1'b0;
        clr_it = 1'b1;
        tick;
        clr_it = 1'b0;
        check("en_low_io", 32'(io[0]), 32'd1);
        repeat (12) tick;
        check("en_low_io2", 32'(io[0]), 32'd1);
        check("en_low_evt", 32'(evt), 32'd0);
        check("en_low_it", 32'(it), 32'd0);
        en = 1'b1;
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("reen_w0", 32'(pat), 32'(exp_pat(10, 1'b1)));
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("reen_w1", 32'(pat), 32'(exp_pat(6, 1'b1)));
        window(-1, 8'd0, pat, ev0, hi1, ev1);
        check("reen_w2", 32'(pat), 32'(exp_pat(2, 1'b1)));

        // Asynchronous reset mid-period
        setup(8'd3, 8'd0, 4'd0, 3'b100);
        repeat (5) tick;
        check("pre_rst_io", 32'(io[0]), 32'd1);
        check("pre_rst_it", 32'(it), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_io", 32'(io), 32'd0);
        check("async_rst_evt", 32'(evt), 32'd0);
        check("async_rst_it", 32'(it), 32'd0);
        tick;
        rstn = 1'b1;
        en   = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
